// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: config word layout, FSM encoding
// and the combinational header decoder.
package weight_loader_pkg;

   localparam int CFG_W          = 32;
   localparam int HDR_LAYER_MSB  = 31;
   localparam int HDR_LAYER_LSB  = 24;
   localparam int HDR_NEURON_MSB = 23;
   localparam int HDR_NEURON_LSB = 12;
   localparam int HDR_COUNT_MSB  = 11;
   localparam int HDR_COUNT_LSB  = 0;
   localparam int LAYER_W        = HDR_LAYER_MSB - HDR_LAYER_LSB + 1;
   localparam int NEURON_W       = HDR_NEURON_MSB - HDR_NEURON_LSB + 1;
   localparam int COUNT_W        = HDR_COUNT_MSB - HDR_COUNT_LSB + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SKIP = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   typedef struct packed {
      logic                layer_hit;
      logic                accept;
      logic [NEURON_W-1:0] neuron;
      logic [COUNT_W-1:0]  count;
   } hdr_dec_t;

   // A header is usable only for our layer, an existing neuron and an exact payload length.
   function automatic hdr_dec_t hdr_decode(input logic [CFG_W-1:0] word,
                                           input int layer_no,
                                           input int num_neuron,
                                           input int num_weight);
      hdr_dec_t r;
      r.layer_hit = (word[HDR_LAYER_MSB:HDR_LAYER_LSB] == LAYER_W'(layer_no));
      r.neuron    = word[HDR_NEURON_MSB:HDR_NEURON_LSB];
      r.count     = word[HDR_COUNT_MSB:HDR_COUNT_LSB];
      r.accept    = r.layer_hit && (r.neuron < NEURON_W'(num_neuron))
                                && (r.count == COUNT_W'(num_weight));
      return r;
   endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Config stream plus weight-memory write port of the weight loader.
interface weight_loader_if
   import weight_loader_pkg::*;
#(
   parameter int numNeuron    = 5,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16
);

   logic [CFG_W-1:0]        cfg_data;
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [numNeuron-1:0]    wen;
   logic [addressWidth-1:0] wadd;
   logic [dataWidth-1:0]    win;
   logic                    load_done;
   logic                    load_err;
   logic [numNeuron-1:0]    loaded;

   modport master (
      output cfg_data, cfg_valid,
      input  cfg_ready, wen, wadd, win, load_done, load_err, loaded
   );

   modport slave (
      input  cfg_data, cfg_valid,
      output cfg_ready, wen, wadd, win, load_done, load_err, loaded
   );

endinterface

// File: rtl/weight_loader.sv
// Streams header + payload config words into one layer's per-neuron weight
// memories; foreign or malformed payloads are consumed and dropped.
module weight_loader
   import weight_loader_pkg::*;
#(
   parameter int numWeight    = 3,
   parameter int numNeuron    = 5,
   parameter int layerNo      = 1,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16
) (
   input logic              clk,
   input logic              rst,
   weight_loader_if.slave   cfg
);

   localparam int SEL_W = (numNeuron > 1) ? $clog2(numNeuron) : 1;
   localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(numWeight - 1);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_LOAD = ST_LOAD;
   localparam logic [1:0] S_SKIP = ST_SKIP;
   localparam logic [1:0] S_FIN  = ST_FIN;

   logic [1:0]              state_q, state_d;
   logic [COUNT_W-1:0]      cnt_q, cnt_d;
   logic [COUNT_W-1:0]      cnt_max_q, cnt_max_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic                    cfg_ready_q, cfg_ready_d;
   logic [numNeuron-1:0]    wen_q, wen_d;
   logic [addressWidth-1:0] wadd_q, wadd_d;
   logic [dataWidth-1:0]    win_q, win_d;
   logic                    load_done_q, load_done_d;
   logic                    load_err_q, load_err_d;
   logic [numNeuron-1:0]    loaded_q, loaded_d;

   logic                    xfer_s;
   hdr_dec_t                hdr_s;
   logic [numNeuron-1:0]    sel_oh_s;

   assign xfer_s = cfg.cfg_valid && cfg_ready_q;
   assign hdr_s  = hdr_decode(cfg.cfg_data, layerNo, numNeuron, numWeight);

   // One-hot view of the latched target neuron.
   always_comb begin
      sel_oh_s = '0;
      for (int i = 0; i < numNeuron; i++) begin
         sel_oh_s[i] = (sel_q == SEL_W'(i));
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cnt_max_d   = cnt_max_q;
      sel_d       = sel_q;
      wen_d       = '0;
      wadd_d      = wadd_q;
      win_d       = win_q;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      loaded_d    = loaded_q;

      case (state_q)
         S_IDLE: begin
            if (xfer_s) begin
               if (hdr_s.accept) begin
                  state_d = S_LOAD;
                  cnt_d   = '0;
                  sel_d   = SEL_W'(hdr_s.neuron);
               end else begin
                  // Foreign-layer headers are dropped without raising an error.
                  load_err_d = hdr_s.layer_hit;
                  cnt_max_d  = hdr_s.count;
                  cnt_d      = '0;
                  if (hdr_s.count != '0) begin
                     state_d = S_SKIP;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (xfer_s) begin
               wen_d  = sel_oh_s;
               wadd_d = addressWidth'(cnt_q);
               win_d  = cfg.cfg_data[dataWidth-1:0];
               cnt_d  = cnt_q + 12'd1;
               if (cnt_q == LAST_IDX) begin
                  state_d     = S_FIN;
                  load_done_d = 1'b1;
                  loaded_d    = loaded_q | sel_oh_s;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_SKIP: begin
            if (xfer_s) begin
               cnt_d = cnt_q + 12'd1;
               if (cnt_q == (cnt_max_q - 12'd1)) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_SKIP;
               end
            end else begin
               state_d = S_SKIP;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      cfg_ready_d = (state_d != S_FIN);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cnt_max_q   <= '0;
         sel_q       <= '0;
         cfg_ready_q <= 1'b1;
         wen_q       <= '0;
         wadd_q      <= '0;
         win_q       <= '0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         loaded_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cnt_max_q   <= cnt_max_d;
         sel_q       <= sel_d;
         cfg_ready_q <= cfg_ready_d;
         wen_q       <= wen_d;
         wadd_q      <= wadd_d;
         win_q       <= win_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
         loaded_q    <= loaded_d;
      end
   end

   assign cfg.cfg_ready = cfg_ready_q;
   assign cfg.wen       = wen_q;
   assign cfg.wadd      = wadd_q;
   assign cfg.win       = win_q;
   assign cfg.load_done = load_done_q;
   assign cfg.load_err  = load_err_q;
   assign cfg.loaded    = loaded_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: drives config words on the falling edge and
// checks registered outputs 1ns after each rising edge.
module tb_weight_loader;

   logic clk;
   logic rst;

   weight_loader_if #(.numNeuron(5), .addressWidth(10), .dataWidth(16)) bus ();

   weight_loader #(
      .numWeight(3), .numNeuron(5), .layerNo(1), .addressWidth(10), .dataWidth(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .cfg (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   logic [15:0] mem [5][8];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] hdr(input int l, input int n, input int c);
      return {8'(l), 12'(n), 12'(c)};
   endfunction

   // One clock: drive at negedge, sample 1ns after posedge and log writes.
   task automatic cyc(input logic v, input logic [31:0] d);
      @(negedge clk);
      bus.cfg_valid = v;
      bus.cfg_data  = d;
      @(posedge clk);
      #1;
      if (bus.wen != 5'b0) begin
         wr_cnt++;
         for (int i = 0; i < 5; i++) begin
            if (bus.wen[i]) mem[i][bus.wadd[2:0]] = bus.win;
         end
      end
      if (bus.load_done) done_cnt++;
      if (bus.load_err) err_cnt++;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] w, input logic [9:0] a, input logic [15:0] d);
      check_eq({tag, "_wen"},  32'(bus.wen),  32'(w));
      check_eq({tag, "_wadd"}, 32'(bus.wadd), 32'(a));
      check_eq({tag, "_win"},  32'(bus.win),  32'(d));
   endtask

   initial begin
      int d0;
      int w0;
      int e0;
      for (int i = 0; i < 5; i++) for (int j = 0; j < 8; j++) mem[i][j] = 16'h0;
      rst = 1'b1;
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready",  32'(bus.cfg_ready), 32'h1);
      check_eq("rst_wen",    32'(bus.wen),       32'h0);
      check_eq("rst_wadd",   32'(bus.wadd),      32'h0);
      check_eq("rst_win",    32'(bus.win),       32'h0);
      check_eq("rst_done",   32'(bus.load_done), 32'h0);
      check_eq("rst_err",    32'(bus.load_err),  32'h0);
      check_eq("rst_loaded", 32'(bus.loaded),    32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Bad headers from our own layer: flagged and their payload skipped.
      cyc(1'b1, hdr(1, 7, 3));
      check_eq("bad_neuron_err", 32'(bus.load_err), 32'h1);
      check_eq("bad_neuron_wen", 32'(bus.wen),      32'h0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0000_0100 + 32'(i));
      check_eq("bad_skip_err",   32'(bus.load_err), 32'h0);
      cyc(1'b1, hdr(1, 0, 2));
      check_eq("bad_count_err",  32'(bus.load_err), 32'h1);
      for (int i = 0; i < 2; i++) cyc(1'b1, 32'h0000_0200 + 32'(i));
      check_eq("bad_wr_cnt",     32'(wr_cnt),       32'h0);
      check_eq("bad_err_cnt",    32'(err_cnt),      32'h2);
      check_eq("bad_loaded",     32'(bus.loaded),   32'h0);

      // Full-rate load of neuron 2.
      cyc(1'b1, hdr(1, 2, 3));
      check_eq("t1_hdr_wen", 32'(bus.wen), 32'h0);
      cyc(1'b1, 32'h0000_0011);
      chk_wr("t1_w0", 5'b00100, 10'd0, 16'h0011);
      check_eq("t1_w0_done", 32'(bus.load_done), 32'h0);
      cyc(1'b1, 32'h0000_0022);
      chk_wr("t1_w1", 5'b00100, 10'd1, 16'h0022);
      cyc(1'b1, 32'h0000_0033);
      chk_wr("t1_w2", 5'b00100, 10'd2, 16'h0033);
      check_eq("t1_done",   32'(bus.load_done), 32'h1);
      check_eq("t1_loaded", 32'(bus.loaded),    32'h4);
      check_eq("t1_ready",  32'(bus.cfg_ready), 32'h0);
      cyc(1'b0, 32'h0);
      check_eq("t1_ready_back", 32'(bus.cfg_ready), 32'h1);
      check_eq("t1_done_pulse", 32'(bus.load_done), 32'h0);
      check_eq("t1_wen_off",    32'(bus.wen),       32'h0);

      // Reload neuron 2 with two-cycle stalls between words.
      d0 = done_cnt;
      cyc(1'b1, hdr(1, 2, 3));
      cyc(1'b1, 32'hFFFF_0044);
      chk_wr("t2_w0", 5'b00100, 10'd0, 16'h0044);
      cyc(1'b0, 32'h0000_9999);
      check_eq("t2_gap0_wen", 32'(bus.wen), 32'h0);
      cyc(1'b0, 32'h0000_9999);
      check_eq("t2_gap1_wen", 32'(bus.wen), 32'h0);
      cyc(1'b1, 32'h0000_0055);
      chk_wr("t2_w1", 5'b00100, 10'd1, 16'h0055);
      cyc(1'b0, 32'h0);
      cyc(1'b0, 32'h0);
      check_eq("t2_gap2_wen", 32'(bus.wen), 32'h0);
      cyc(1'b1, 32'h0000_0066);
      chk_wr("t2_w2", 5'b00100, 10'd2, 16'h0066);
      cyc(1'b0, 32'h0);
      check_eq("t2_done_once", 32'(done_cnt - d0), 32'h1);
      check_eq("t2_mem0", 32'(mem[2][0]), 32'h44);
      check_eq("t2_mem1", 32'(mem[2][1]), 32'h55);
      check_eq("t2_mem2", 32'(mem[2][2]), 32'h66);
      check_eq("t2_loaded", 32'(bus.loaded), 32'h4);

      // Foreign layer payload is consumed silently.
      w0 = wr_cnt;
      e0 = err_cnt;
      cyc(1'b1, hdr(2, 0, 4));
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 32'h0000_0300 + 32'(i));
         check_eq("t3_skip_ready", 32'(bus.cfg_ready), 32'h1);
      end
      check_eq("t3_no_wr",  32'(wr_cnt - w0),  32'h0);
      check_eq("t3_no_err", 32'(err_cnt - e0), 32'h0);
      cyc(1'b1, hdr(1, 0, 3));
      cyc(1'b1, 32'h0000_00A1);
      chk_wr("t3_w0", 5'b00001, 10'd0, 16'h00A1);
      cyc(1'b1, 32'h0000_00A2);
      cyc(1'b1, 32'h0000_00A3);
      chk_wr("t3_w2", 5'b00001, 10'd2, 16'h00A3);
      check_eq("t3_loaded", 32'(bus.loaded), 32'h5);
      check_eq("t3_mem1",   32'(mem[0][1]),  32'hA2);
      cyc(1'b0, 32'h0);

      // Zero-count foreign header stays in IDLE; the next word is a header.
      cyc(1'b1, hdr(2, 0, 0));
      check_eq("t6_ready", 32'(bus.cfg_ready), 32'h1);
      check_eq("t6_err",   32'(bus.load_err),  32'h0);
      cyc(1'b1, hdr(1, 4, 3));
      cyc(1'b1, 32'h0000_00D1);
      chk_wr("t6_w0", 5'b10000, 10'd0, 16'h00D1);
      cyc(1'b1, 32'h0000_00D2);
      cyc(1'b1, 32'h0000_00D3);
      check_eq("t6_loaded", 32'(bus.loaded), 32'h15);
      cyc(1'b0, 32'h0);

      // Asynchronous reset in the middle of a payload.
      cyc(1'b1, hdr(1, 3, 3));
      cyc(1'b1, 32'h0000_00B1);
      chk_wr("t5_w0", 5'b01000, 10'd0, 16'h00B1);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("t5_rst_wen",    32'(bus.wen),       32'h0);
      check_eq("t5_rst_loaded", 32'(bus.loaded),    32'h0);
      check_eq("t5_rst_ready",  32'(bus.cfg_ready), 32'h1);
      check_eq("t5_rst_win",    32'(bus.win),       32'h0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, hdr(1, 3, 3));
      check_eq("t5_hdr_wen", 32'(bus.wen), 32'h0);
      cyc(1'b1, 32'h0000_00C1);
      chk_wr("t5_w0b", 5'b01000, 10'd0, 16'h00C1);
      cyc(1'b1, 32'h0000_00C2);
      chk_wr("t5_w1b", 5'b01000, 10'd1, 16'h00C2);
      cyc(1'b1, 32'h0000_00C3);
      chk_wr("t5_w2b", 5'b01000, 10'd2, 16'h00C3);
      check_eq("t5_done",   32'(bus.load_done), 32'h1);
      check_eq("t5_loaded", 32'(bus.loaded),    32'h8);
      cyc(1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
